// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with level interrupt on the bridge bus.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (tick every DIV clk cycles).
module timer_dev #(
  parameter int unsigned DIV   = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_pend_q, irq_pend_d;
  logic             irq_q, irq_d;
  logic             tick;
  logic             ctrl_wr, preset_wr;

  assign ctrl_wr   = WE && (Addr == 2'd0);
  assign preset_wr = WE && (Addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    presc_d = '0;
    if (state_q == CNT && ctrl_q[0] && !tick)
      presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  // Without the prescaler every cycle is a tick (DIV is never zero).
  assign tick = (DIV != 0);
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;

    if (ctrl_wr)
      irq_pend_d = 1'b0;

    case (state_q)
      IDLE: if (ctrl_q[0]) state_d = LOAD;
      LOAD: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q <= WIDTH'(1)) begin
            count_d    = '0;
            irq_pend_d = 1'b1;
            state_d    = INT;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          irq_pend_d = 1'b0;
          state_d    = ctrl_q[0] ? LOAD : IDLE;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU writes override any FSM update of CTRL made above.
    if (ctrl_wr)
      ctrl_d = DIn[3:0];
    if (preset_wr)
      preset_d = WIDTH'(DIn);

    irq_d = ctrl_d[3] & irq_pend_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      2'd0:    DOut = {28'd0, ctrl_q};
      2'd1:    DOut = 32'(preset_q);
      2'd2:    DOut = 32'(count_q);
      default: DOut = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: register reset, one-shot, auto-reload,
// EN clear/reload, asynchronous reset mid-count and (with TIMER_PRESCALE_EN) the prescaler.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer_dev #(.DIV(4), .WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  // Consumes exactly one rising edge (the write edge); returns 1 time unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; DIn = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    $display("write addr=%0d data=0x%0h", a, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Addr = 2'd0; WE = 1'b0; DIn = '0;
    repeat (2) @(posedge clk);
    #1 chk("irq_in_reset", 32'(IRQ), 32'd0);
    @(negedge clk) reset = 1'b1;

    // 1: reset values
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    chk_rd("rst_rsvd", 2'd3, 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);

    // 2: one-shot, PRESET=5, IRQ at edge 7
    wr(2'd1, 32'd5);
    chk_rd("os_preset", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step();
    for (int e = 2; e <= 7; e++) begin
      step();
      chk_rd($sformatf("os_count_e%0d", e), 2'd2, 32'(7 - e));
      chk($sformatf("os_irq_e%0d", e), 32'(IRQ), (e == 7) ? 32'd1 : 32'd0);
    end
    step();
    chk_rd("os_ctrl_after", 2'd0, 32'h8);
    chk("os_irq_hold", 32'(IRQ), 32'd1);
    wr(2'd0, 32'h8);
    chk("os_irq_clear", 32'(IRQ), 32'd0);

    // 3: auto-reload PRESET=3 (period 5), PRESET=6 written mid-count (period 8 later)
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 24; e++) begin
      if (e == 13) begin
        wr(2'd1, 32'd6);
        chk_rd("ar_count_unaffected", 2'd2, 32'd2);
      end else begin
        step();
      end
      if (e == 17) chk_rd("ar_reload6", 2'd2, 32'd6);
      chk($sformatf("ar_irq_e%0d", e), 32'(IRQ),
          (e == 5 || e == 10 || e == 15 || e == 23) ? 32'd1 : 32'd0);
    end
    wr(2'd0, 32'h0);
    step(); step();
    chk("ar_stop_irq", 32'(IRQ), 32'd0);

    // 4: clear EN after 4 ticks -> COUNT freezes at 6; re-enable reloads 10
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (5) step();
    wr(2'd0, 32'h8);
    for (int e = 0; e < 4; e++) begin
      step();
      chk_rd($sformatf("frz_count_%0d", e), 2'd2, 32'd6);
      chk($sformatf("frz_irq_%0d", e), 32'(IRQ), 32'd0);
    end
    wr(2'd0, 32'h9);
    step(); step();
    chk_rd("reen_count", 2'd2, 32'd10);

    // 5: async reset while COUNT=3
    repeat (7) step();
    chk_rd("pre_rst_count", 2'd2, 32'd3);
    #1 reset = 1'b0;
    #1 chk("arst_irq", 32'(IRQ), 32'd0);
    chk_rd("arst_ctrl", 2'd0, 32'd0);
    chk_rd("arst_preset", 2'd1, 32'd0);
    chk_rd("arst_count", 2'd2, 32'd0);
    @(negedge clk) reset = 1'b1;

`ifdef TIMER_PRESCALE_EN
    // 6: DIV=4, PRESET=2 -> COUNT steps every 4 cycles, COUNT writes ignored
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    step(); step();
    chk_rd("ps_load", 2'd2, 32'd2);
    repeat (3) step();
    chk_rd("ps_hold", 2'd2, 32'd2);
    step();
    chk_rd("ps_step1", 2'd2, 32'd1);
    wr(2'd2, 32'hFFFF);
    chk_rd("ps_count_wr_ignored", 2'd2, 32'd1);
    step(); step();
    chk_rd("ps_hold2", 2'd2, 32'd1);
    chk("ps_irq_low", 32'(IRQ), 32'd0);
    step();
    chk_rd("ps_zero", 2'd2, 32'd0);
    chk("ps_irq_high", 32'(IRQ), 32'd1);
`else
    wr(2'd2, 32'hFFFF);
    chk_rd("count_wr_ignored", 2'd2, 32'd0);
    wr(2'd3, 32'h1234);
    chk_rd("rsvd_wr_ignored", 2'd3, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
